// File: rtl/mul_pipe.sv
// Purpose : fixed-latency pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with a hazard port.
// Latency : STAGES cycles from accept to out_valid; one accept per unstalled cycle.
// Backpressure: stall freezes every stage (upstream holds its inputs); flush kills all in-flight ops.
//
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_op/in_a/in_b/in_rd  : operation from issue
//   stall, flush                    : pipeline control (flush beats stall and accept)
//   query_rs1/query_rs2             : issue-side source registers for the hazard check
//   out_valid/out_rd/out_result     : result from the last stage to writeback
//   busy                            : any stage holds a valid operation
//   hazard                          : a query register matches a non-zero in-flight rd
module mul_pipe #(
   parameter int XLEN           = 32,
   parameter int STAGES         = 5,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [1:0]                in_op,
   input  logic [XLEN-1:0]           in_a,
   input  logic [XLEN-1:0]           in_b,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [REG_ADDR_WIDTH-1:0] query_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] query_rs2,
   output logic                      out_valid,
   output logic [REG_ADDR_WIDTH-1:0] out_rd,
   output logic [XLEN-1:0]           out_result,
   output logic                      busy,
   output logic                      hazard
);

   localparam int PW   = 2 * XLEN;      // kept product width
   localparam int EW   = 2 * XLEN + 2;  // extended operand width
   localparam int LAST = STAGES - 1;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   // Per-stage state; index 0 is stage 1.
   logic                      valid_q [STAGES];
   logic [REG_ADDR_WIDTH-1:0] rd_q    [STAGES];
   logic [1:0]                op_q    [STAGES];
   logic [PW-1:0]             prod_q  [STAGES];

   logic                      accept;
   logic                      a_signed;
   logic                      b_signed;
   logic signed [EW-1:0]      a_ext;
   logic signed [EW-1:0]      b_ext;
   logic [PW-1:0]             prod_d;

   assign accept = in_valid & ~stall & ~flush;

   // Only MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
   // The extra two bits let one signed multiplier cover every sign combination,
   // and truncating to PW bits leaves the exact 64-bit product.
   always_comb begin
      a_signed = (in_op != OP_MULHU);
      b_signed = ~in_op[1];
      a_ext    = {{(EW-XLEN){in_a[XLEN-1] & a_signed}}, in_a};
      b_ext    = {{(EW-XLEN){in_b[XLEN-1] & b_signed}}, in_b};
      prod_d   = PW'(a_ext * b_ext);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            rd_q[k]    <= '0;
            op_q[k]    <= '0;
            prod_q[k]  <= '0;
         end
      end else if (flush) begin
         // Data fields may stay stale; only the valid bits matter.
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
         end
      end else if (!stall) begin
         valid_q[0] <= accept;
         if (accept) begin
            rd_q[0]   <= in_rd;
            op_q[0]   <= in_op;
            prod_q[0] <= prod_d;
         end
         for (int k = 1; k < STAGES; k++) begin
            valid_q[k] <= valid_q[k-1];
            rd_q[k]    <= rd_q[k-1];
            op_q[k]    <= op_q[k-1];
            prod_q[k]  <= prod_q[k-1];
         end
      end
   end

   // Hazard includes the last stage: its result has not been written back yet.
   always_comb begin
      busy   = 1'b0;
      hazard = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         busy = busy | valid_q[k];
         if (valid_q[k] && (rd_q[k] != '0) &&
             ((rd_q[k] == query_rs1) || (rd_q[k] == query_rs2))) begin
            hazard = 1'b1;
         end
      end
   end

   always_comb begin
      out_valid = valid_q[LAST];
      out_rd    = rd_q[LAST];
      if (!valid_q[LAST]) begin
         out_result = '0;
      end else if (op_q[LAST] == OP_MUL) begin
         out_result = prod_q[LAST][XLEN-1:0];
      end else begin
         out_result = prod_q[LAST][PW-1:XLEN];
      end
   end

endmodule

// File: tb/tb_mul_pipe.sv
// Purpose : self-checking bench for mul_pipe against a queue-of-ages reference model.
// Latency : model expects a result STAGES unstalled edges after acceptance.
// Backpressure: stall/flush exercised in directed steps and random traffic.
module tb_mul_pipe;

   localparam int XLEN   = 32;
   localparam int STAGES = 5;
   localparam int RW     = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic [1:0]      in_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic [RW-1:0]   in_rd;
   logic            stall;
   logic            flush;
   logic [RW-1:0]   query_rs1;
   logic [RW-1:0]   query_rs2;
   logic            out_valid;
   logic [RW-1:0]   out_rd;
   logic [XLEN-1:0] out_result;
   logic            busy;
   logic            hazard;

   mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .REG_ADDR_WIDTH(RW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
      .stall(stall), .flush(flush),
      .query_rs1(query_rs1), .query_rs2(query_rs2),
      .out_valid(out_valid), .out_rd(out_rd), .out_result(out_result),
      .busy(busy), .hazard(hazard)
   );

   always #5 clk = ~clk;

   // Reference model: list of in-flight ops, oldest first, each with the
   // number of pipeline advances it has seen since acceptance.
   typedef struct {
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] res;
      int              age;
   } ent_t;

   ent_t q[$];
   int checks   = 0;
   int failures = 0;

   // RV32M semantics with plain 64-bit modular arithmetic.
   function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
      eb = (op == 2'b00 || op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      ent_t e;
      if (reset || flush) begin
         q.delete();
      end else if (!stall) begin
         foreach (q[i]) q[i].age++;
         while (q.size() > 0 && q[0].age > STAGES) void'(q.pop_front());
         if (in_valid) begin
            e.rd  = in_rd;
            e.res = ref_result(in_op, in_a, in_b);
            e.age = 1;
            q.push_back(e);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic exp_v, exp_h;
      exp_v = (q.size() > 0) && (q[0].age == STAGES);
      exp_h = 1'b0;
      foreach (q[i]) begin
         if (q[i].rd != 0 && (q[i].rd == query_rs1 || q[i].rd == query_rs2)) exp_h = 1'b1;
      end
      check({tag, "_valid"}, out_valid, exp_v);
      check({tag, "_result"}, out_result, exp_v ? q[0].res : '0);
      if (exp_v) check({tag, "_rd"}, out_rd, q[0].rd);
      check({tag, "_busy"}, busy, q.size() > 0);
      check({tag, "_hazard"}, hazard, exp_h);
   endtask

   // One clock edge: model sees the inputs applied before it, outputs checked #1 after.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [RW-1:0] rd);
      in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      query_rs1 = '0; query_rs2 = '0;
      drive(1'b0, 2'b00, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_rd", out_rd, '0);
      check("rst_result", out_result, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_hazard", hazard, 1'b0);
      reset = 1'b0;

      // 1: single MUL, latency STAGES
      drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd3);
      step("t1");
      idle();
      check("t1_busy1", busy, 1'b1);
      repeat (3) step("t1");
      check("t1_early", out_valid, 1'b0);
      step("t1");
      check("t1_vld", out_valid, 1'b1);
      check("t1_rd", out_rd, 5'd3);
      check("t1_res", out_result, 32'd42);
      step("t1");
      check("t1_gone", out_valid, 1'b0);

      // 2: back-to-back ops
      drive(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1); step("t2");
      drive(1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2); step("t2");
      drive(1'b1, 2'b10, 32'hFFFFFFFF, 32'd2, 5'd5);        step("t2");
      drive(1'b1, 2'b00, 32'h80000000, 32'd2, 5'd6);        step("t2");
      idle();
      step("t2"); check("t2_r0", out_result, 32'h00000000); check("t2_v0", out_valid, 1'b1);
      step("t2"); check("t2_r1", out_result, 32'hFFFFFFFE);
      step("t2"); check("t2_r2", out_result, 32'hFFFFFFFF);
      step("t2"); check("t2_r3", out_result, 32'h00000000); check("t2_v3", out_valid, 1'b1);
      step("t2"); check("t2_end", out_valid, 1'b0);

      // 3: stall delays result, stall with out_valid high holds it
      drive(1'b1, 2'b00, 32'd3, 32'd5, 5'd7); step("t3");
      idle(); step("t3");
      stall = 1'b1; repeat (3) step("t3");
      stall = 1'b0; repeat (2) step("t3");
      check("t3_late", out_valid, 1'b0);
      step("t3");
      check("t3_vld", out_valid, 1'b1);
      check("t3_res", out_result, 32'd15);
      stall = 1'b1;
      repeat (3) begin
         step("t3s");
         check("t3_hold", out_result, 32'd15);
      end
      stall = 1'b0; step("t3");
      check("t3_gone", out_valid, 1'b0);

      // 4: flush together with stall kills everything
      drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd8); step("t4");
      drive(1'b1, 2'b11, 32'd4, 32'd4, 5'd9); step("t4");
      idle(); stall = 1'b1; flush = 1'b1;
      step("t4");
      check("t4_busy", busy, 1'b0);
      stall = 1'b0; flush = 1'b0;
      repeat (7) step("t4");

      // 5: hazard tracking, rd=0 never hazards
      query_rs2 = 5'd4;
      drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd4); step("t5");
      idle();
      check("t5_haz", hazard, 1'b1);
      repeat (5) step("t5");
      check("t5_haz_off", hazard, 1'b0);
      query_rs1 = '0; query_rs2 = '0;
      drive(1'b1, 2'b00, 32'd11, 32'd3, 5'd0); step("t5z");
      idle();
      check("t5_haz_rd0", hazard, 1'b0);
      repeat (4) step("t5z");
      check("t5_rd0_vld", out_valid, 1'b1);
      check("t5_rd0_res", out_result, 32'd33);
      step("t5z");

      // random traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom,
               5'($urandom_range(0, 7)));
         stall     = ($urandom_range(0, 4) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         query_rs1 = 5'($urandom_range(0, 7));
         query_rs2 = 5'($urandom_range(0, 7));
         step("rnd");
      end
      stall = 1'b0; flush = 1'b0; idle();
      repeat (STAGES + 1) step("rnd_drain");

      // 6: asynchronous reset mid-clock with three ops in flight
      query_rs1 = 5'd1; query_rs2 = 5'd2;
      drive(1'b1, 2'b00, 32'd5, 32'd5, 5'd1); step("t6");
      drive(1'b1, 2'b01, 32'd6, 32'd6, 5'd2); step("t6");
      drive(1'b1, 2'b11, 32'd7, 32'd7, 5'd3); step("t6");
      idle();
      check("t6_busy_pre", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      q.delete();
      check("t6_valid", out_valid, 1'b0);
      check("t6_rd", out_rd, '0);
      check("t6_result", out_result, '0);
      check("t6_busy", busy, 1'b0);
      check("t6_hazard", hazard, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (STAGES + 2) step("t6_post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Fixed-latency pipelined multiplier for the RV32M multiply operations. It sits in the execute stage beside the ALU and takes operands and destination register from decode/issue. It carries each operation through `STAGES` registered stages with stall and flush control. Results go to the writeback arbiter. A combinational hazard port lets the issue logic block dependent instructions while a product is in flight.

## Interface
- `XLEN`, 32, operand and result width.
- `STAGES`, 5, latency in cycles from accept to `out_valid`; legal range 1..8.
- `REG_ADDR_WIDTH`, 5, destination register index width.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation presented this cycle.
- `in_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_a`, `in_b`  in  XLEN  rs1 and rs2 operand values.
- `in_rd`  in  REG_ADDR_WIDTH  destination register.
- `stall`  in  1  freeze all stages.
- `flush`  in  1  kill every in-flight operation.
- `query_rs1`, `query_rs2`  in  REG_ADDR_WIDTH  source registers of the instruction in issue.
- `out_valid`  out  1  result available from the last stage.
- `out_rd`  out  REG_ADDR_WIDTH  destination of the result.
- `out_result`  out  XLEN  selected 32-bit result.
- `busy`  out  1  OR of all stage valid bits.
- `hazard`  out  1  a query register matches an in-flight `rd`.

## Operation
- Each stage holds `valid`, `rd`, `op` and a 2*XLEN-bit product.
  - The product is computed from the input operands and written into stage 1.
  - Stages 2..STAGES copy the product forward unchanged.
- Accept condition is `in_valid & ~stall & ~flush`.
  - On accept, stage 1 captures `valid=1` and the signed/unsigned product:
    - MUL: signed × signed.
    - MULH: signed × signed.
    - MULHSU: signed a × unsigned b.
    - MULHU: unsigned × unsigned.
  - Both operands are extended to 2*XLEN+2 bits before multiplying; the low 2*XLEN bits are kept.
  - If `in_valid` is high but the operation is not accepted, stage 1 captures `valid=0`. This applies only when `flush` is high; under `stall` the stage holds.
- Advance rule:
  - `stall=0`: every stage k>1 takes the contents of stage k-1.
  - `stall=1`: every stage holds, including stage 1. Upstream must hold its inputs during a stall.
- Flush:
  - On the next edge every stage `valid` becomes 0.
  - Flush has priority over stall and over accept.
  - Data fields may keep stale values.
- Result selection, from the last stage:
  - MUL: low XLEN bits.
  - Other ops: high XLEN bits.
  - `out_result` is forced to 0 when `out_valid=0`.
- Hazard:
  - `hazard` = OR over all stages of (`valid` & `rd != 0` & (`rd == query_rs1` | `rd == query_rs2`)).
  - It is purely combinational from the stage registers and query inputs.
  - The last stage is included, because writeback has not yet happened.
  - rd=0 never raises a hazard; an operation with rd=0 still flows and produces `out_valid`.
- Reset: all `valid`, `rd`, `op` and product registers clear to 0 immediately on `reset` assertion.
  - `out_valid=0`, `out_rd=0`, `out_result=0`, `busy=0`, `hazard=0`.
  - Reset asserted mid-operation discards all in-flight work.

## Timing
- Latency: an operation accepted at edge t gives `out_valid=1` after edge t+STAGES-1, i.e. during cycle t+STAGES-1 to t+STAGES. With STAGES=5 it appears 5 cycles after the accept cycle.
- Throughput: one accept per unstalled cycle; back-to-back operations produce back-to-back results.
- Stall while `out_valid=1`:
  - The output is held stable for every stalled cycle.
  - Writeback must commit only on a cycle with `stall=0`, so each result commits exactly once.
- Simultaneous events:
  - `flush` with `stall`: flush wins; all valids are 0 after the edge.
  - `flush` with `in_valid`: the input is dropped.
  - `reset` overrides everything asynchronously.
- `busy` and `hazard` reflect the current register state. They update the same cycle the stage contents change; there is no extra delay.

## Test plan
1. After reset deassert, MUL with a=7, b=6, rd=3 accepted at cycle 0 -> `out_valid` only in cycle 5, `out_rd=3`, `out_result=42`; `busy=1` in cycles 1-5.
2. Four back-to-back ops, one per cycle, accepted at cycles 0-3 -> `out_valid` in cycles 5-8 in order with correct results:
   - MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
   - MUL 0x80000000×2 -> 0x00000000.
3. Accept MUL 3×5 at cycle 0, then `stall` high for cycles 2-4 -> result appears 3 cycles later (cycle 8). Inject a second stall with `out_valid` high -> `out_result=15` held stable throughout.
4. Two ops in flight, `flush` and `stall` both high in the same cycle -> `busy=0` next cycle and no `out_valid` ever appears for either op.
5. Op with rd=4 in flight:
   - `query_rs2=4` -> `hazard=1` every cycle until `out_valid` drops.
   - An op with rd=0 and `query_rs1=0` -> `hazard=0`.
6. Assert `reset` asynchronously mid-clock with three ops in flight -> all outputs 0 before the next edge; no stale result after reset release.
